popcount_accum: RTL and testbench

POPCOUNT_ACCUM -- requirements
Module: popcount_accum

---
 rtl/popcount_pkg.sv | 24 ++
 rtl/popcount_tree.sv | 18 +
 rtl/popcount_accum.sv | 128 ++++++++++++
 tb/tb_popcount_accum.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// Shared types for the ternary popcount accumulator: FSM states and
// activation encodings, plus the threshold compare used to form out_act.
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN,
    DONE
  } state_e;

  localparam logic [1:0] ACT_POS  = 2'b01;
  localparam logic [1:0] ACT_ZERO = 2'b00;
  localparam logic [1:0] ACT_NEG  = 2'b11;

  // Operands arrive sign-extended to 32 bits so that -thr cannot overflow.
  function automatic logic [1:0] ternary_act(input logic signed [31:0] sum,
                                             input logic signed [31:0] thr);
    if (sum > thr) return ACT_POS;
    if (sum < -thr) return ACT_NEG;
    return ACT_ZERO;
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Exact combinational population count of a WIDTH-bit vector.
module popcount_tree #(
  parameter int unsigned WIDTH = 29
) (
  input  logic [WIDTH-1:0]           bits,
  output logic [$clog2(WIDTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/popcount_accum.sv
// Ternary neuron evaluation: per-beat lane difference popcount, saturating
// accumulation over num_beats beats, then thresholded ternary activation.
module popcount_accum
  import popcount_pkg::*;
#(
  parameter int unsigned WIDTH  = 29,
  parameter int unsigned ACC_W  = 12,
  parameter int unsigned BEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BEAT_W-1:0] num_beats,
  input  logic [ACC_W-1:0]  threshold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_pos,
  input  logic [WIDTH-1:0]  in_neg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [1:0]        out_act
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned DW = CW + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  if (ACC_W < $clog2(WIDTH) + 2 || ACC_W > 31) begin : g_bad_acc_w
    $error("popcount_accum: ACC_W too narrow for WIDTH (or above 31)");
  end

  logic [CW-1:0]           pc_pos, pc_neg;
  logic signed [DW-1:0]    diff;
  logic                    xfer;
  logic signed [ACC_W:0]   s1_ext, sum_ext;

  state_e                  state_q, state_d;
  logic [BEAT_W-1:0]       beats_q, beats_d;
  logic signed [DW-1:0]    s1_q, s1_d;
  logic                    s1_vld_q, s1_vld_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] thr_q, thr_d;
  logic [ACC_W-1:0]        out_sum_q, out_sum_d;
  logic [1:0]              out_act_q, out_act_d;

  popcount_tree #(.WIDTH(WIDTH)) u_pc_pos (.bits(in_pos & ~in_neg), .count(pc_pos));
  popcount_tree #(.WIDTH(WIDTH)) u_pc_neg (.bits(in_neg & ~in_pos), .count(pc_neg));

  assign diff = $signed({1'b0, pc_pos}) - $signed({1'b0, pc_neg});

  always_comb begin
    xfer      = (state_q == ACC) && in_valid;
    s1_ext    = {{(ACC_W+1-DW){s1_q[DW-1]}}, s1_q};
    sum_ext   = {acc_q[ACC_W-1], acc_q} + s1_ext;
    state_d   = state_q;
    beats_d   = beats_q;
    acc_d     = acc_q;
    thr_d     = thr_q;
    out_sum_d = out_sum_q;
    out_act_d = out_act_q;
    s1_d      = xfer ? diff : '0;
    s1_vld_d  = xfer;

    // One guard bit above the accumulator exposes overflow for clamping.
    if (s1_vld_q) begin
      if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) acc_d = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
      else acc_d = sum_ext[ACC_W-1:0];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          beats_d = (num_beats == '0) ? BEAT_W'(1) : num_beats;
          acc_d   = '0;
          thr_d   = threshold;
        end
      end
      ACC: begin
        if (in_valid) begin
          beats_d = beats_q - BEAT_W'(1);
          if (beats_q == BEAT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_vld_q) begin
          state_d   = DONE;
          out_sum_d = acc_q;
          out_act_d = ternary_act(32'(acc_q), 32'(thr_q));
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beats_q   <= '0;
      s1_q      <= '0;
      s1_vld_q  <= 1'b0;
      acc_q     <= '0;
      thr_q     <= '0;
      out_sum_q <= '0;
      out_act_q <= ACT_ZERO;
    end else begin
      state_q   <= state_d;
      beats_q   <= beats_d;
      s1_q      <= s1_d;
      s1_vld_q  <= s1_vld_d;
      acc_q     <= acc_d;
      thr_q     <= thr_d;
      out_sum_q <= out_sum_d;
      out_act_q <= out_act_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign out_sum   = out_sum_q;
  assign out_act   = out_act_q;

endmodule

// File: tb/tb_popcount_accum.sv
// Directed bench for popcount_accum: two instances (ACC_W=12 and ACC_W=8)
// share stimulus and are checked every cycle against a behavioural model.
module tb_popcount_accum;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, out_ready;
  logic [7:0]  num_beats;
  logic [11:0] threshold;
  logic [28:0] in_pos, in_neg;

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [11:0] out_sum_a;
  logic [7:0]  out_sum_b;
  logic [1:0]  out_act_a, out_act_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_xfer = 0;

  // Model state
  bit m_collect, m_outv, m_fresh;
  int m_left, m_wait, m_s12, m_s8, m_thr12, m_thr8;

  popcount_accum #(.WIDTH(29), .ACC_W(12), .BEAT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .num_beats(num_beats),
    .threshold(threshold), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_pos(in_pos), .in_neg(in_neg), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_sum(out_sum_a), .out_act(out_act_a)
  );

  popcount_accum #(.WIDTH(29), .ACC_W(8), .BEAT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .num_beats(num_beats),
    .threshold(threshold[7:0]), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_pos(in_pos), .in_neg(in_neg), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_sum(out_sum_b), .out_act(out_act_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int beat_diff(input logic [28:0] p, input logic [28:0] n);
    int d = 0;
    for (int i = 0; i < 29; i++) begin
      if (p[i] && !n[i]) d++;
      else if (n[i] && !p[i]) d--;
    end
    return d;
  endfunction

  function automatic int sat(input int v, input int w);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  function automatic int act_exp(input int s, input int t);
    return (s > t) ? 1 : (s < -t) ? 3 : 0;
  endfunction

  // Behavioural model: evaluation = collect N beats, result 3 cycles later,
  // held until accepted; start only counts when nothing is in flight.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_collect = 0; m_outv = 0; m_fresh = 1;
      m_left = 0; m_wait = 0; m_s12 = 0; m_s8 = 0; m_thr12 = 0; m_thr8 = 0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_outv = 1;
    end else if (m_outv) begin
      if (out_ready) m_outv = 0;
    end else if (m_collect) begin
      if (in_valid) begin
        m_s12 = sat(m_s12 + beat_diff(in_pos, in_neg), 12);
        m_s8  = sat(m_s8 + beat_diff(in_pos, in_neg), 8);
        m_left--;
        if (m_left == 0) begin
          m_collect = 0;
          m_wait = 2;
        end
      end
    end else if (start) begin
      m_collect = 1;
      m_left = (num_beats == 0) ? 1 : int'(num_beats);
      m_s12 = 0; m_s8 = 0;
      m_thr12 = int'($signed(threshold));
      m_thr8 = int'($signed(threshold[7:0]));
      m_fresh = 0;
    end
  end

  always @(negedge clk) begin
    int sa, sb;
    sa = int'($signed(out_sum_a));
    sb = int'($signed(out_sum_b));
    chk("in_ready_a", in_ready_a, m_collect);
    chk("in_ready_b", in_ready_b, m_collect);
    chk("out_valid_a", out_valid_a, m_outv);
    chk("out_valid_b", out_valid_b, m_outv);
    if (m_outv || m_fresh) begin
      chk("out_sum_a", sa, m_fresh ? 0 : m_s12);
      chk("out_sum_b", sb, m_fresh ? 0 : m_s8);
      chk("out_act_a", out_act_a, m_fresh ? 0 : act_exp(m_s12, m_thr12));
      chk("out_act_b", out_act_b, m_fresh ? 0 : act_exp(m_s8, m_thr8));
    end
  end

  task automatic do_start(input int nb, input int thr);
    @(negedge clk);
    start = 1'b1; num_beats = 8'(nb); threshold = 12'(thr);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [28:0] p, input logic [28:0] n, input int bubbles);
    int k = 0;
    repeat (bubbles) @(negedge clk);
    while (!in_ready_a && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_wait", in_ready_a, 1);
    in_valid = 1'b1; in_pos = p; in_neg = n;
    t_xfer = cyc;
    @(negedge clk);
    in_valid = 1'b0; in_pos = '1; in_neg = '0;
  endtask

  task automatic wait_valid(input int sa, input int sb, input int aa, input int ab);
    int k = 0;
    while (!out_valid_a && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("result_arrives", out_valid_a, 1);
    chk("latency", cyc - t_xfer, 3);
    chk("lit_sum_a", int'($signed(out_sum_a)), sa);
    chk("lit_sum_b", int'($signed(out_sum_b)), sb);
    chk("lit_act_a", out_act_a, aa);
    chk("lit_act_b", out_act_b, ab);
  endtask

  task automatic accept(input int hold);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    num_beats = '0; threshold = '0; in_pos = '0; in_neg = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready_a, 0);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_sum", int'(out_sum_a), 0);
    chk("rst_out_act", out_act_a, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Single full-positive beat
    do_start(1, 17);
    send_beat('1, '0, 0);
    wait_valid(29, 29, 1, 1);
    accept(0);

    // Three full-negative beats with a bubble
    do_start(3, 40);
    send_beat('0, '1, 0);
    send_beat('0, '1, 1);
    send_beat('0, '1, 0);
    wait_valid(-87, -87, 3, 3);
    accept(1);

    // num_beats=0 behaves as one beat; cancelling lanes
    do_start(0, 0);
    send_beat('1, '1, 0);
    chk("one_beat_only", in_ready_a, 0);
    wait_valid(0, 0, 0, 0);
    accept(0);

    // Saturation in the narrow instance and hold under backpressure
    do_start(10, 100);
    for (int i = 0; i < 10; i++) send_beat('1, '0, 0);
    wait_valid(290, 127, 1, 1);
    repeat (5) @(negedge clk);
    chk("held_valid_b", out_valid_b, 1);
    chk("held_sum_b", int'($signed(out_sum_b)), 127);
    accept(0);

    // Reset mid-evaluation aborts; fresh evaluation afterwards
    do_start(4, 0);
    send_beat(29'h7, '0, 0);
    send_beat(29'h7, '0, 0);
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_valid", out_valid_a, 0);
    do_start(1, 0);
    send_beat(29'h1F, '0, 0);
    wait_valid(5, 5, 1, 1);
    accept(0);

    // start ignored in ACC, DONE and on the DONE->IDLE handshake
    do_start(2, 0);
    send_beat(29'h0F, 29'h30, 0);
    do_start(1, 50);
    send_beat(29'hFF, 29'h0F, 2);
    wait_valid(6, 6, 1, 1);
    do_start(3, 5);
    chk("done_start_sum", int'($signed(out_sum_a)), 6);
    chk("done_start_valid", out_valid_a, 1);
    out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    chk("handshake_start_ignored", in_ready_a, 0);
    chk("handshake_released", out_valid_a, 0);
    repeat (3) @(negedge clk);
    chk("still_idle", in_ready_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
